// File: rtl/radio_grid_ctrl_if.sv
// Radio grid controller port bundle: packet handshake, clear control,
// display read port and status outputs.
interface radio_grid_ctrl_if;
   logic [6:0] pkt_in;
   logic       pkt_valid;
   logic       pkt_ready;
   logic       clear_req;
   logic       busy;
   logic [2:0] rd_x;
   logic [1:0] rd_y;
   logic [1:0] rd_value;
   logic       update_stb;
   logic [7:0] err_count;

   modport master (
      output pkt_in,
      output pkt_valid,
      output clear_req,
      output rd_x,
      output rd_y,
      input  pkt_ready,
      input  busy,
      input  rd_value,
      input  update_stb,
      input  err_count
   );

   modport slave (
      input  pkt_in,
      input  pkt_valid,
      input  clear_req,
      input  rd_x,
      input  rd_y,
      output pkt_ready,
      output busy,
      output rd_value,
      output update_stb,
      output err_count
   );
endinterface

// File: rtl/radio_grid_ctrl.sv
// Maze grid store fed by radio packets, with a clear sweep and display read.
// Define RADIO_GRID_ERRCNT_EN to count dropped out-of-range packets.
module radio_grid_ctrl #(
   parameter int GRID_W = 5,
   parameter int GRID_H = 4
) (
   input logic               clk,
   input logic               rst,
   radio_grid_ctrl_if.slave  bus
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLEAR
   } state_t;

   typedef struct packed {
      logic [2:0] x;
      logic [1:0] y;
      logic [1:0] val;
   } pkt_t;

   state_t        state;
   state_t        state_nxt;
   pkt_t          hold;
   logic [AW-1:0] sweep;
   logic [1:0]    grid [CELLS];
   logic [1:0]    rd_value_q;
   logic          update_stb_q;

   logic          take;
   logic          wr_hit;
   logic          rd_hit;
   logic          sweep_last;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign bus.pkt_ready = (state == IDLE) && !bus.clear_req && !rst;
   assign bus.busy       = (state == CLEAR);
   assign bus.rd_value   = rd_value_q;
   assign bus.update_stb = update_stb_q;

   assign take = bus.pkt_valid && bus.pkt_ready;

   assign wr_hit = (int'(hold.x) < GRID_W) && (int'(hold.y) < GRID_H);
   assign wr_idx = AW'(int'(hold.y) * GRID_W + int'(hold.x));

   assign rd_hit = (int'(bus.rd_x) < GRID_W) && (int'(bus.rd_y) < GRID_H);
   assign rd_idx = AW'(int'(bus.rd_y) * GRID_W + int'(bus.rd_x));

   assign sweep_last = (int'(sweep) == CELLS - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Clear wins over a simultaneous packet; take already excludes clear_req.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.clear_req) begin
               state_nxt = CLEAR;
            end else if (take) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            state_nxt = IDLE;
         end
         CLEAR: begin
            if (sweep_last) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Read samples the grid before this edge's write: read-old-on-collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold         <= '0;
         sweep        <= '0;
         rd_value_q   <= '0;
         update_stb_q <= 1'b0;
         for (int i = 0; i < CELLS; i++) begin
            grid[i] <= '0;
         end
      end else begin
         update_stb_q <= 1'b0;
         if (take) begin
            hold <= pkt_t'(bus.pkt_in);
         end
         if (state == WRITE && wr_hit) begin
            grid[wr_idx] <= hold.val;
            update_stb_q <= 1'b1;
         end
         if (state == CLEAR) begin
            grid[sweep] <= '0;
            sweep       <= sweep_last ? '0 : sweep + 1'b1;
         end
         rd_value_q <= rd_hit ? grid[rd_idx] : '0;
      end
   end

`ifdef RADIO_GRID_ERRCNT_EN
   logic [7:0] err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else if (state == WRITE && !wr_hit && err_q != 8'hFF) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign bus.err_count = err_q;
`else
   assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_radio_grid_ctrl.sv
// Directed bench for radio_grid_ctrl: vector table plus hand-written
// sequences for bursts, clear sweep, reset abort and read/write collision.
module tb_radio_grid_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   radio_grid_ctrl_if bus ();

   radio_grid_ctrl #(
      .GRID_W(5),
      .GRID_H(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

`ifdef RADIO_GRID_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int x;
      int y;
      int v;
      int rx;
      int ry;
      int stb;
      int rd;
   } vec_t;

   vec_t       tv [11];
   logic [6:0] bq [$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         errs = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [6:0] pk(input int x, input int y, input int v);
      return {3'(x), 2'(y), 2'(v)};
   endfunction

   function automatic int exp_err();
      if (!ERR_EN) return 0;
      return (errs > 255) ? 255 : errs;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.pkt_valid = 1'b0;
      bus.clear_req = 1'b0;
      errs = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic read_cell(input int x, input int y, output int v);
      @(negedge clk);
      bus.rd_x = 3'(x);
      bus.rd_y = 2'(y);
      @(negedge clk);
      v = int'(bus.rd_value);
   endtask

   task automatic burst(output int pulses, output int bad_gap, output int acc);
      int last;
      last = -1;
      pulses = 0;
      bad_gap = 0;
      acc = 0;
      for (int c = 0; c < bq.size() * 2 + 6; c++) begin
         @(negedge clk);
         if (bus.update_stb) begin
            if (last >= 0 && c - last != 2) bad_gap++;
            last = c;
            pulses++;
         end
         if (acc < bq.size()) begin
            bus.pkt_in = bq[acc];
            bus.pkt_valid = 1'b1;
            if (bus.pkt_ready) acc++;
         end else begin
            bus.pkt_valid = 1'b0;
         end
      end
      bus.pkt_valid = 1'b0;
   endtask

   initial begin
      int v, p, g, a, cnt, live, rbad, bad;

      tv[0]  = '{2, 2, 3, 2, 2, 1, 3};
      tv[1]  = '{0, 0, 1, 0, 0, 1, 1};
      tv[2]  = '{4, 3, 2, 4, 3, 1, 2};
      tv[3]  = '{6, 1, 3, 4, 1, 0, 0};
      tv[4]  = '{5, 0, 1, 0, 1, 0, 0};
      tv[5]  = '{7, 3, 3, 2, 2, 0, 3};
      tv[6]  = '{0, 1, 2, 5, 0, 1, 0};
      tv[7]  = '{3, 1, 1, 0, 1, 1, 2};
      tv[8]  = '{2, 2, 0, 2, 2, 1, 0};
      tv[9]  = '{1, 3, 3, 7, 3, 1, 0};
      tv[10] = '{4, 0, 1, 1, 3, 1, 3};

      rst = 1'b1;
      bus.pkt_in = '0;
      bus.pkt_valid = 1'b0;
      bus.clear_req = 1'b0;
      bus.rd_x = '0;
      bus.rd_y = '0;

      // reset state
      @(negedge clk);
      chk("rst_ready", int'(bus.pkt_ready), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_stb", int'(bus.update_stb), 0);
      chk("rst_err", int'(bus.err_count), 0);
      chk("rst_rd", int'(bus.rd_value), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", int'(bus.pkt_ready), 1);

      // table vectors: single packet, strobe timing, error count, readback
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), int'(bus.pkt_ready), 1);
         bus.pkt_in = pk(tv[i].x, tv[i].y, tv[i].v);
         bus.pkt_valid = 1'b1;
         bus.rd_x = 3'(tv[i].rx);
         bus.rd_y = 2'(tv[i].ry);
         @(negedge clk);
         bus.pkt_valid = 1'b0;
         chk($sformatf("v%0d_stb_early", i), int'(bus.update_stb), 0);
         @(negedge clk);
         chk($sformatf("v%0d_stb", i), int'(bus.update_stb), tv[i].stb);
         if (tv[i].stb == 0) errs++;
         chk($sformatf("v%0d_err", i), int'(bus.err_count), exp_err());
         @(negedge clk);
         chk($sformatf("v%0d_rd", i), int'(bus.rd_value), tv[i].rd);
      end

      // read/write collision on (0,0)
      do_reset();
      @(negedge clk);
      bus.rd_x = 3'd0;
      bus.rd_y = 2'd0;
      bus.pkt_in = pk(0, 0, 2);
      bus.pkt_valid = 1'b1;
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      @(negedge clk);
      chk("coll_stb", int'(bus.update_stb), 1);
      chk("coll_old", int'(bus.rd_value), 0);
      @(negedge clk);
      chk("coll_new", int'(bus.rd_value), 2);

      // back-to-back burst of 4 with valid held
      bq = '{pk(1, 0, 1), pk(2, 0, 2), pk(3, 0, 3), pk(4, 1, 1)};
      burst(p, g, a);
      chk("b4_accepted", a, 4);
      chk("b4_pulses", p, 4);
      chk("b4_gaps", g, 0);
      read_cell(1, 0, v); chk("b4_c0", v, 1);
      read_cell(2, 0, v); chk("b4_c1", v, 2);
      read_cell(3, 0, v); chk("b4_c2", v, 3);
      read_cell(4, 1, v); chk("b4_c3", v, 1);

      // error count saturation
      do_reset();
      bq.delete();
      for (int i = 0; i < 300; i++) bq.push_back(pk(6, 1, 3));
      burst(p, g, a);
      errs += 300;
      chk("sat_accepted", a, 300);
      chk("sat_pulses", p, 0);
      chk("sat_err", int'(bus.err_count), exp_err());
      read_cell(1, 1, v); chk("sat_grid", v, 0);

      // fill, then clear with a simultaneous pending packet
      do_reset();
      bq.delete();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 5; x++) bq.push_back(pk(x, y, 1));
      burst(p, g, a);
      chk("fill_pulses", p, 20);
      @(negedge clk);
      bus.rd_x = 3'd4;
      bus.rd_y = 2'd3;
      bus.pkt_in = pk(1, 1, 3);
      bus.pkt_valid = 1'b1;
      bus.clear_req = 1'b1;
      #1;
      chk("clr_ready_low", int'(bus.pkt_ready), 0);
      @(negedge clk);
      bus.clear_req = 1'b0;
      cnt = 0;
      live = 0;
      rbad = 0;
      for (int c = 0; c < 40; c++) begin
         if (!bus.busy) break;
         cnt++;
         if (bus.rd_value == 2'd1) live++;
         if (bus.pkt_ready) rbad++;
         bus.clear_req = (cnt == 5);
         @(negedge clk);
      end
      bus.clear_req = 1'b0;
      chk("clr_busy_cycles", cnt, 20);
      chk("clr_read_live", live, 20);
      chk("clr_ready_busy", rbad, 0);
      chk("clr_ready_after", int'(bus.pkt_ready), 1);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      @(negedge clk);
      chk("clr_pending_stb", int'(bus.update_stb), 1);
      bad = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 5; x++) begin
            read_cell(x, y, v);
            if (v != ((x == 1 && y == 1) ? 3 : 0)) bad++;
         end
      chk("clr_cells", bad, 0);

      // reset during sweep cycle 7
      bq = '{pk(4, 3, 3), pk(0, 0, 2)};
      burst(p, g, a);
      chk("ab_pulses", p, 2);
      @(negedge clk);
      bus.clear_req = 1'b1;
      @(negedge clk);
      bus.clear_req = 1'b0;
      for (int i = 0; i < 7; i++) @(negedge clk);
      chk("ab_busy_pre", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk("ab_busy_drop", int'(bus.busy), 0);
      chk("ab_rd_zero", int'(bus.rd_value), 0);
      chk("ab_ready_rst", int'(bus.pkt_ready), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ab_ready_rel", int'(bus.pkt_ready), 1);
      read_cell(4, 3, v); chk("ab_c19", v, 0);
      read_cell(1, 1, v); chk("ab_c6", v, 0);
      read_cell(0, 0, v); chk("ab_c0", v, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
